// File: rtl/reg_bank_wb_if.sv
// reg_bank_wb_if
//   Bus bundle between the write decoder / CPU datapath and the register bank.
//   Write side : wr_en, sel0..sel7 (one-hot), wr_data, clr_err
//   Read side  : rd_add_a/rd_add_b -> rd_data_a/rd_data_b (combinational)
//   Status     : wb_busy (pending write in holding stage), wr_err (sticky)
//   Modports   : master drives requests/addresses, slave is the register bank.
interface reg_bank_wb_if #(
    parameter int unsigned WIDTH = 8
);
    logic             wr_en;
    logic             sel0, sel1, sel2, sel3, sel4, sel5, sel6, sel7;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       rd_add_a;
    logic [2:0]       rd_add_b;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             wb_busy;
    logic             wr_err;

    modport master (
        output wr_en, sel0, sel1, sel2, sel3, sel4, sel5, sel6, sel7,
        output wr_data, rd_add_a, rd_add_b, clr_err,
        input  rd_data_a, rd_data_b, wb_busy, wr_err
    );

    modport slave (
        input  wr_en, sel0, sel1, sel2, sel3, sel4, sel5, sel6, sel7,
        input  wr_data, rd_add_a, rd_add_b, clr_err,
        output rd_data_a, rd_data_b, wb_busy, wr_err
    );
endinterface

// File: rtl/reg_bank_wb.sv
// reg_bank_wb
//   8-entry register bank fed by the write decoder's one-hot selects. Each
//   accepted write is captured into a one-entry holding stage and committed to
//   the array on the following edge; both read ports forward from that stage.
//   Writes whose select is not exactly one-hot are dropped and flagged on the
//   sticky wr_err.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : reg_bank_wb_if.slave (write request, read ports, status)
module reg_bank_wb #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst_n,
    reg_bank_wb_if.slave bus
);

    logic [WIDTH-1:0] regs [8];
    logic             wb_valid;
    logic [2:0]       wb_idx;
    logic [WIDTH-1:0] wb_data;
    logic             wr_err_q;

    logic [7:0]       sel;
    logic             sel_ok;
    logic [2:0]       idx;
    logic             capture;
    logic             bad_write;

    // One-hot check: non-zero and no more than one bit set.
    always_comb begin
        sel     = {bus.sel7, bus.sel6, bus.sel5, bus.sel4,
                   bus.sel3, bus.sel2, bus.sel1, bus.sel0};
        sel_ok  = (sel != '0) && ((sel & (sel - 8'd1)) == '0);
        idx     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sel[i]) begin
                idx = 3'(i);
            end
        end
        capture   = bus.wr_en && sel_ok;
        bad_write = bus.wr_en && !sel_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= RESET_VAL;
            end
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_data  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            // Commit of the pending write and capture of the next one share
            // an edge, giving one write per cycle without stalling.
            if (wb_valid) begin
                regs[wb_idx] <= wb_data;
            end
            if (capture) begin
                wb_valid <= 1'b1;
                wb_idx   <= idx;
                wb_data  <= bus.wr_data;
            end else begin
                wb_valid <= 1'b0;
            end
            // Set has priority over clear.
            if (bad_write) begin
                wr_err_q <= 1'b1;
            end else if (bus.clr_err) begin
                wr_err_q <= 1'b0;
            end
        end
    end

    // Reads bypass from the holding stage; current-cycle wr_data is not forwarded.
    always_comb begin
        bus.rd_data_a = (wb_valid && (wb_idx == bus.rd_add_a)) ? wb_data : regs[bus.rd_add_a];
        bus.rd_data_b = (wb_valid && (wb_idx == bus.rd_add_b)) ? wb_data : regs[bus.rd_add_b];
        bus.wb_busy   = wb_valid;
        bus.wr_err    = wr_err_q;
    end

endmodule
